mf_cen_gen: RTL and testbench

MF_CEN_GEN -- requirements
Module: mf_cen_gen

---
 rtl/mf_cen_gen.sv | 92 +++++++++
 tb/tb_mf_cen_gen.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mf_cen_gen.sv
// Multi-channel fractional clock-enable generator with lock detect; optional square outputs under MF_CEN_GEN_SQUARE_EN.
// Latency: cen registers the accumulator carry, one cycle after the overflowing add; locked is decoded from the lock counter.
// Backpressure: none; free-running every refclk cycle, gated per channel by en and realigned by sync.
module mf_cen_gen #(
  parameter int NUM_CH      = 3,
  parameter int ACC_W       = 32,
  parameter int LOCK_CYCLES = 1024
) (
  input  logic                    refclk,
  input  logic                    rst_n,
  input  logic [NUM_CH*ACC_W-1:0] inc,
  input  logic [NUM_CH*ACC_W-1:0] phase,
  input  logic [NUM_CH-1:0]       en,
  input  logic                    sync,
  output logic [NUM_CH-1:0]       cen,
  output logic                    locked
`ifdef MF_CEN_GEN_SQUARE_EN
  ,
  output logic [NUM_CH-1:0]       clk_sq
`endif
);

  localparam int CNT_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(LOCK_CYCLES);

  logic [NUM_CH*ACC_W-1:0] inc_q;
  logic                    inc_chg;
  logic [CNT_W-1:0]        lock_cnt;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [ACC_W-1:0] acc_r;
      logic             cen_r;
      logic [ACC_W:0]   sum;

      // The carry out of the wide sum is the enable; the low bits keep the fractional residue.
      assign sum = {1'b0, acc_r} + {1'b0, inc[gi*ACC_W +: ACC_W]};

      always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
          acc_r <= '0;
          cen_r <= 1'b0;
        end else if (sync) begin
          acc_r <= phase[gi*ACC_W +: ACC_W];
          cen_r <= 1'b0;
        end else if (en[gi]) begin
          acc_r <= sum[ACC_W-1:0];
          cen_r <= sum[ACC_W];
        end else begin
          cen_r <= 1'b0;
        end
      end

      assign cen[gi] = cen_r;

`ifdef MF_CEN_GEN_SQUARE_EN
      logic sq_r;

      always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
          sq_r <= 1'b0;
        end else begin
          sq_r <= acc_r[ACC_W-1];
        end
      end

      assign clk_sq[gi] = sq_r;
`endif
    end
  endgenerate

  assign inc_chg = (inc != inc_q);

  // A frequency-word change and a sync in the same cycle collapse into one clear.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      inc_q    <= '0;
      lock_cnt <= '0;
    end else begin
      inc_q <= inc;
      if (inc_chg || sync) begin
        lock_cnt <= '0;
      end else if (lock_cnt != LOCK_MAX) begin
        lock_cnt <= lock_cnt + CNT_W'(1);
      end
    end
  end

  assign locked = (lock_cnt == LOCK_MAX);

endmodule

// File: tb/tb_mf_cen_gen.sv
// Scoreboarded bench for mf_cen_gen: a cycle-level arithmetic model queues expected cen/locked, a monitor compares.
module tb_mf_cen_gen;
  localparam int NUM_CH = 3;
  localparam int ACC_W  = 4;
  localparam int LOCK   = 8;
  localparam int MOD    = 1 << ACC_W;

  typedef struct {
    logic [NUM_CH-1:0] cen;
    logic              locked;
  } exp_t;

  logic                    refclk;
  logic                    rst_n;
  logic [NUM_CH*ACC_W-1:0] inc;
  logic [NUM_CH*ACC_W-1:0] phase;
  logic [NUM_CH-1:0]       en;
  logic                    sync;
  logic [NUM_CH-1:0]       cen;
  logic                    locked;
`ifdef MF_CEN_GEN_SQUARE_EN
  logic [NUM_CH-1:0]       clk_sq;
`endif

  logic [ACC_W-1:0] inc_v   [NUM_CH];
  logic [ACC_W-1:0] phase_v [NUM_CH];
  logic [NUM_CH-1:0] en_v;
  logic              sync_v;

  int   m_acc  [NUM_CH];
  int   m_prev [NUM_CH];
  int   m_lock;
  exp_t exp_q[$];

  int checks;
  int errors;

  mf_cen_gen #(.NUM_CH(NUM_CH), .ACC_W(ACC_W), .LOCK_CYCLES(LOCK)) dut (
    .refclk (refclk),
    .rst_n  (rst_n),
    .inc    (inc),
    .phase  (phase),
    .en     (en),
    .sync   (sync),
    .cen    (cen),
    .locked (locked)
`ifdef MF_CEN_GEN_SQUARE_EN
    ,
    .clk_sq (clk_sq)
`endif
  );

  initial begin
    refclk = 1'b0;
    forever #5 refclk = ~refclk;
  end

  always_comb begin
    inc   = '0;
    phase = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      inc[i*ACC_W +: ACC_W]   = inc_v[i];
      phase[i*ACC_W +: ACC_W] = phase_v[i];
    end
    en   = en_v;
    sync = sync_v;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_acc[i]  = 0;
      m_prev[i] = 0;
    end
    m_lock = 0;
    exp_q.delete();
  endtask

  // Advance the model by one refclk edge with the current inputs, queue the result, move to the next negedge.
  task automatic tick();
    exp_t e;
    bit   chg;
    int   s;
    chg = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(inc_v[i]) != m_prev[i]) chg = 1;
      if (sync_v) begin
        m_acc[i] = int'(phase_v[i]);
        e.cen[i] = 1'b0;
      end else if (en_v[i]) begin
        s        = m_acc[i] + int'(inc_v[i]);
        e.cen[i] = (s >= MOD);
        m_acc[i] = s % MOD;
      end else begin
        e.cen[i] = 1'b0;
      end
      m_prev[i] = int'(inc_v[i]);
    end
    if (chg || sync_v) m_lock = 0;
    else if (m_lock < LOCK) m_lock++;
    e.locked = (m_lock == LOCK);
    exp_q.push_back(e);
    @(negedge refclk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge refclk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (cen !== e.cen) begin
          errors++;
          $display("FAIL sb_cen @%0t: got %b expected %b", $time, cen, e.cen);
        end
        checks++;
        if (locked !== e.locked) begin
          errors++;
          $display("FAIL sb_locked @%0t: got %b expected %b", $time, locked, e.locked);
        end
      end
    end
  end

  initial begin : driver
    int first0, npulse, last, gapbad, relock, found, c;
    int off [NUM_CH];
    int pl[$];
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    sync_v = 1'b0;
    en_v   = '1;
    for (int i = 0; i < NUM_CH; i++) begin
      inc_v[i]   = '0;
      phase_v[i] = '0;
    end
    model_reset();
    repeat (3) @(negedge refclk);
    chk("reset_cen", int'(cen), 0);
    chk("reset_locked", int'(locked), 0);

    // First pulse timing from reset and steady period of inc=4.
    inc_v[0] = 4'd4;
    inc_v[1] = 4'd7;
    inc_v[2] = 4'd9;
    rst_n = 1'b1;
    model_reset();
    first0 = 0; npulse = 0; last = 0; gapbad = 0;
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (cen[0]) begin
        if (first0 == 0) first0 = k;
        if (last > 0 && (k - last) != 4) gapbad++;
        last = k;
        npulse++;
      end
    end
    chk("a_first_pulse", first0, 4);
    chk("a_pulse_count", npulse, 6);
    chk("a_gap_errors", gapbad, 0);
    chk("a_locked", int'(locked), 1);

    // One-bit change of inc[1] drops lock for exactly LOCK cycles.
    inc_v[1] = inc_v[1] ^ 4'd1;
    tick();
    chk("a_lock_drop", int'(locked), 0);
    relock = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (locked && relock == 0) relock = k;
    end
    chk("a_relock", relock, LOCK);

    // inc=3 from acc=0: nine pulses in 48 cycles spaced 5,5,6.
    inc_v[0] = 4'd3;
    for (int i = 0; i < NUM_CH; i++) phase_v[i] = '0;
    sync_v = 1'b1;
    tick();
    sync_v = 1'b0;
    for (int k = 1; k <= 48; k++) begin
      tick();
      if (cen[0]) pl.push_back(k);
    end
    chk("b_pulse_count", pl.size(), 9);
    for (int j = 1; j < pl.size(); j++)
      chk("b_gap", pl[j] - pl[j-1], (j % 3 == 0) ? 6 : 5);

    // Sync realignment with staggered phases.
    for (int i = 0; i < NUM_CH; i++) inc_v[i] = 4'd4;
    phase_v[0] = 4'd0;
    phase_v[1] = 4'd8;
    phase_v[2] = 4'd4;
    sync_v = 1'b1;
    tick();
    sync_v = 1'b0;
    chk("c_cen_after_sync", int'(cen), 0);
    for (int i = 0; i < NUM_CH; i++) off[i] = 0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      for (int i = 0; i < NUM_CH; i++)
        if (cen[i] && off[i] == 0) off[i] = k;
    end
    chk("c_off_ch0", off[0], 4);
    chk("c_off_ch1", off[1], 2);
    chk("c_off_ch2", off[2], 3);

    // Hold channel 0 for 10 cycles mid-run; it resumes from acc=8.
    for (int i = 0; i < NUM_CH; i++) phase_v[i] = '0;
    sync_v = 1'b1;
    tick();
    sync_v = 1'b0;
    repeat (6) tick();
    en_v[0] = 1'b0;
    npulse = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (cen[0]) npulse++;
    end
    chk("d_hold_pulses", npulse, 0);
    en_v[0] = 1'b1;
    first0 = 0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (cen[0] && first0 == 0) first0 = k;
    end
    chk("d_resume_pulse", first0, 2);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        c = $urandom_range(0, NUM_CH - 1);
        inc_v[c] = ($urandom_range(0, 3) == 0) ? '0 : ACC_W'($urandom_range(0, MOD - 1));
      end
      for (int i = 0; i < NUM_CH; i++) en_v[i] = ($urandom_range(0, 99) < 85);
      sync_v = ($urandom_range(0, 19) == 0);
      if (sync_v)
        for (int i = 0; i < NUM_CH; i++) phase_v[i] = ACC_W'($urandom_range(0, MOD - 1));
      tick();
    end

    // Asynchronous reset while cen and locked are high.
    sync_v = 1'b0;
    en_v   = '1;
    inc_v[0] = 4'd4;
    inc_v[1] = 4'd5;
    inc_v[2] = 4'd6;
    found = 0;
    for (int k = 0; k < 40 && found == 0; k++) begin
      tick();
      if (cen[0] && locked) found = 1;
    end
    chk("e_pre_reset_state", found, 1);
    rst_n = 1'b0;
    #1;
    chk("e_async_cen", int'(cen), 0);
    chk("e_async_locked", int'(locked), 0);
    @(negedge refclk);
    repeat (2) @(negedge refclk);
    chk("e_in_reset_cen", int'(cen), 0);
    rst_n = 1'b1;
    model_reset();
    first0 = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (cen[0] && first0 == 0) first0 = k;
    end
    chk("e_first_after_reset", first0, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
